pload_serializer: RTL and testbench
===================================

PLOAD_SERIALIZER -- requirements
Module: pload_serializer

Interface
REQ-001 The block SHALL have parameter LOAD_WIDTH, default 32, giving the parallel load word width in bits.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 8, giving the serial beat width in bits.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1; 1 sends the most-significant beat first, 0 sends the least-significant beat first.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 din  input  LOAD_WIDTH  SHALL carry the parallel word to serialize.
REQ-007 din_valid  input  1  SHALL indicate that din holds a word to load.
REQ-008 din_ready  output  1  SHALL indicate that the block accepts din this cycle.
REQ-009 dout  output  OUT_WIDTH  SHALL carry the current serial beat.
REQ-010 dout_valid  output  1  SHALL indicate that dout holds a valid beat.
REQ-011 dout_ready  input  1  SHALL indicate that the downstream consumer takes the beat this cycle.
REQ-012 dout_last  output  1  SHALL mark the final beat of a word.
REQ-013 busy  output  1  SHALL be high while a word is being serialized.

Function
REQ-014 Define BEATS = LOAD_WIDTH/OUT_WIDTH; LOAD_WIDTH SHALL be an integer multiple of OUT_WIDTH with BEATS >= 2, and elaboration SHALL fail otherwise.
REQ-015 The beat counter SHALL be $clog2(BEATS) bits wide, with no fixed-size arrays, so any legal parameter set works.
REQ-016 The state machine SHALL have exactly two states: IDLE and SHIFT.
REQ-017 A load occurs when din_valid && din_ready are both high on a rising clk edge.
REQ-018 din_ready SHALL be combinational: high in IDLE, or in SHIFT when dout_valid && dout_ready && dout_last.
REQ-019 On a load, the block SHALL capture din into the shift register, set the counter to BEATS-1, and enter SHIFT.
REQ-020 The first beat SHALL appear on dout with dout_valid=1 in the cycle after the load, giving 1-cycle latency.
REQ-021 A beat SHALL advance only on dout_valid && dout_ready; while dout_ready=0, dout, dout_last and the counter SHALL hold.
REQ-022 With MSB_FIRST=1, the beats SHALL be din[LOAD_WIDTH-1 -: OUT_WIDTH] first, then descending; with MSB_FIRST=0, din[OUT_WIDTH-1:0] first, then ascending.
REQ-023 dout_last SHALL be high only while the counter equals 0 and dout_valid=1.
REQ-024 When the last beat is taken and no load occurs, the block SHALL return to IDLE with dout_valid=0, dout=0 and busy=0 in the next cycle.
REQ-025 When the last beat is taken and a load occurs in the same cycle, the block SHALL stay in SHIFT and present the new word's first beat in the next cycle, with no bubble.
REQ-026 In IDLE, dout SHALL be 0, and dout_valid, dout_last and busy SHALL be 0.
REQ-027 busy SHALL equal (state == SHIFT).
REQ-028 din SHALL be ignored whenever din_ready=0.
REQ-029 Changes on din after a load SHALL NOT affect beats already captured.

Reset
REQ-030 When reset_n=0, the block SHALL immediately, regardless of clk, force state=IDLE, the shift register to 0 and the counter to 0.
REQ-031 During reset, outputs SHALL be: dout=0, dout_valid=0, dout_last=0, busy=0.
REQ-032 During reset, din_ready SHALL be 0.
REQ-033 A word in flight when reset asserts SHALL be discarded and SHALL NOT resume after reset releases.
REQ-034 The first load SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-035 Scenario: defaults, din=0xA1B2C3D4 loaded, dout_ready=1 -> beats A1, B2, C3, D4 on 4 consecutive cycles starting 1 cycle after the load; dout_last only on D4; busy for 4 cycles.
REQ-036 Scenario: MSB_FIRST=0, same word -> beats D4, C3, B2, A1; dout_last on A1.
REQ-037 Scenario: defaults, dout_ready low for 3 cycles while B2 is presented -> dout holds B2 and din_ready stays 0 for those 3 cycles; the sequence then completes unchanged.
REQ-038 Scenario: 0x11223344 then 0x55667788 with din_valid held and dout_ready=1 -> 8 contiguous beats 11..44, 55..88; dout_valid never drops; dout_last on 44 and on 88.
REQ-039 Scenario: reset_n pulled low asynchronously mid-word after beat B2 -> outputs go to 0 before the next edge; after release, the block is in IDLE and the next load 0xDEADBEEF emits DE, AD, BE, EF.
REQ-040 Scenario: LOAD_WIDTH=48, OUT_WIDTH=16, din=0x0123456789AB -> beats 0123, 4567, 89AB; dout_last on 89AB.

Source files
------------

// File: rtl/pload_serializer.sv
// Parallel-load serializer: captures a LOAD_WIDTH word and emits it as
// OUT_WIDTH beats over a valid/ready stream, MSB- or LSB-beat first.
module pload_serializer #(
  parameter int LOAD_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [LOAD_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [OUT_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy
);

  localparam int BEATS = LOAD_WIDTH / OUT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  generate
    if (((LOAD_WIDTH % OUT_WIDTH) != 0) || ((LOAD_WIDTH / OUT_WIDTH) < 2)) begin : g_param_check
      $error("pload_serializer: LOAD_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
    end
  endgenerate

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [LOAD_WIDTH-1:0]   shreg_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    load_s;
  logic                    take_s;
  logic                    take_last_s;
  logic                    ready_s;

  // The beat on dout is consumed whenever we are shifting and downstream is ready.
  assign take_s      = (state_r == SHIFT) && dout_ready;
  assign take_last_s = take_s && (cnt_r == CNT_ZERO);
  assign ready_s     = reset_n && ((state_r == IDLE) || take_last_s);
  assign load_s      = din_valid && ready_s;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a load on the final beat keeps us in SHIFT with no bubble.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s) state_nxt_s = SHIFT;
        else        state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (take_last_s && !load_s) state_nxt_s = IDLE;
        else                        state_nxt_s = SHIFT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Shift register and beat counter; cleared when the word drains so IDLE holds no stale data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_r <= {LOAD_WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else if (load_s) begin
      shreg_r <= din;
      cnt_r   <= CNT_LAST;
    end else if (take_last_s) begin
      shreg_r <= {LOAD_WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else if (take_s) begin
      if (MSB_FIRST != 0) shreg_r <= shreg_r << OUT_WIDTH;
      else                shreg_r <= shreg_r >> OUT_WIDTH;
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      shreg_r <= shreg_r;
      cnt_r   <= cnt_r;
    end
  end

  // Output decode from state and the head of the shift register.
  always_comb begin
    dout       = {OUT_WIDTH{1'b0}};
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    busy       = 1'b0;
    din_ready  = ready_s;
    if (state_r == SHIFT) begin
      dout_valid = 1'b1;
      busy       = 1'b1;
      dout_last  = (cnt_r == CNT_ZERO);
      if (MSB_FIRST != 0) dout = shreg_r[LOAD_WIDTH-1 -: OUT_WIDTH];
      else                dout = shreg_r[OUT_WIDTH-1:0];
    end else begin
      dout       = {OUT_WIDTH{1'b0}};
      dout_valid = 1'b0;
      dout_last  = 1'b0;
      busy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_pload_serializer.sv
// Self-checking bench: a beat-queue reference model drives random and directed
// traffic on the default instance; two other configurations run fixed words.
module tb_pload_serializer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // default configuration (32/8, MSB first)
  logic [31:0] din0;
  logic        din_valid0, din_ready0, dout_valid0, dout_ready0, dout_last0, busy0;
  logic [7:0]  dout0;

  // LSB-first configuration
  logic [31:0] din1;
  logic        din_valid1, din_ready1, dout_valid1, dout_last1, busy1;
  logic [7:0]  dout1;

  // 48/16 configuration
  logic [47:0] din2;
  logic        din_valid2, din_ready2, dout_valid2, dout_last2, busy2;
  logic [15:0] dout2;

  pload_serializer dut0 (
    .clk(clk), .reset_n(reset_n), .din(din0), .din_valid(din_valid0), .din_ready(din_ready0),
    .dout(dout0), .dout_valid(dout_valid0), .dout_ready(dout_ready0), .dout_last(dout_last0),
    .busy(busy0));

  pload_serializer #(.LOAD_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .din(din1), .din_valid(din_valid1), .din_ready(din_ready1),
    .dout(dout1), .dout_valid(dout_valid1), .dout_ready(1'b1), .dout_last(dout_last1),
    .busy(busy1));

  pload_serializer #(.LOAD_WIDTH(48), .OUT_WIDTH(16), .MSB_FIRST(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .din(din2), .din_valid(din_valid2), .din_ready(din_ready2),
    .dout(dout2), .dout_valid(dout_valid2), .dout_ready(1'b1), .dout_last(dout_last2),
    .busy(busy2));

  // beats still owed by the default instance, head = beat on dout
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle0(input string tag);
    check({tag, "_dout"}, 64'(dout0), 64'd0);
    check({tag, "_valid"}, 64'(dout_valid0), 64'd0);
    check({tag, "_last"}, 64'(dout_last0), 64'd0);
    check({tag, "_busy"}, 64'(busy0), 64'd0);
  endtask

  // One cycle on the default instance: drive, compare against the model, advance the model.
  task automatic step(input logic v, input logic [31:0] d, input logic r);
    logic exp_ready;
    int   n;
    @(negedge clk);
    din_valid0 = v;
    din0 = d;
    dout_ready0 = r;
    #1;
    n = exp_q.size();
    exp_ready = reset_n && ((n == 0) || (r && n == 1));
    check("dout_valid", 64'(dout_valid0), 64'(n != 0));
    check("dout", 64'(dout0), (n != 0) ? 64'(exp_q[0]) : 64'd0);
    check("dout_last", 64'(dout_last0), 64'(n == 1));
    check("busy", 64'(busy0), 64'(n != 0));
    check("din_ready", 64'(din_ready0), 64'(exp_ready));
    if (n != 0 && r) void'(exp_q.pop_front());
    if (v && exp_ready) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((d >> (8 * (3 - i))) & 32'hFF));
    end
  endtask

  initial begin
    logic [7:0]  e1 [4];
    logic [15:0] e2 [3];
    e1 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    e2 = '{16'h0123, 16'h4567, 16'h89AB};
    din0 = 32'd0; din_valid0 = 1'b1; dout_ready0 = 1'b1;
    din1 = 32'd0; din_valid1 = 1'b0;
    din2 = 48'd0; din_valid2 = 1'b0;

    // reset state, din_ready must stay low while reset is held
    #12;
    check_idle0("rst");
    check("rst_din_ready", 64'(din_ready0), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    din_valid0 = 1'b0;

    // basic word, full throughput
    step(1'b1, 32'hA1B2C3D4, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'hFFFF_FFFF, 1'b1);

    // back-pressure on the second beat
    step(1'b1, 32'hA1B2C3D4, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    // two words back to back with din_valid held
    step(1'b1, 32'h11223344, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h55667788, 1'b1);
    step(1'b1, 32'h55667788, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

    // asynchronous reset mid-word, just after B2 is taken
    step(1'b1, 32'hA1B2C3D4, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle0("async_rst");
    check("async_rst_din_ready", 64'(din_ready0), 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 40; i++) step(1'b0, 32'h0, 1'b1);

    // LSB-first and 48/16 instances
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      din_valid1 = (k == 0);
      din_valid2 = (k == 0);
      din1 = (k == 0) ? 32'hA1B2C3D4 : 32'h5A5A_5A5A;
      din2 = (k == 0) ? 48'h0123456789AB : 48'hFFFF_0000_FFFF;
      #1;
      if (k >= 1 && k <= 4) begin
        check("lsb_dout", 64'(dout1), 64'(e1[k-1]));
        check("lsb_last", 64'(dout_last1), 64'(k == 4));
        check("lsb_busy", 64'(busy1), 64'd1);
      end else begin
        check("lsb_valid", 64'(dout_valid1), 64'd0);
        check("lsb_dout_idle", 64'(dout1), 64'd0);
      end
      if (k >= 1 && k <= 3) begin
        check("w48_dout", 64'(dout2), 64'(e2[k-1]));
        check("w48_last", 64'(dout_last2), 64'(k == 3));
        check("w48_valid", 64'(dout_valid2), 64'd1);
      end else begin
        check("w48_valid", 64'(dout_valid2), 64'd0);
        check("w48_busy", 64'(busy2), 64'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
